piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 178 +++++++++++++++++
 tb/tb_piso_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-entry holding register for gapless frames.
// Optional even-parity trailer cycle is enabled by defining SER_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_active,
  output logic             frame_done
);

  localparam int unsigned   CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;
  logic             xfer;
  logic             last_bit;
  logic             frame_end;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Bit order only changes which end of the shift register is presented and refilled.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit = shift_q[WIDTH-1];
      assign shifted  = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit = shift_q[0];
      assign shifted  = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign xfer     = load_valid & ready_q;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

`ifdef SER_PARITY_EN
  assign frame_end = (state_q == PARITY);
`else
  assign frame_end = last_bit;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
`ifdef SER_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d  = load_data;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SER_PARITY_EN
          parity_d = ^load_data;
`endif
        end
      end
      SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
`ifdef SER_PARITY_EN
        if (last_bit) begin
          state_d = PARITY;
        end
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        state_d = PARITY;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Mid-frame offers park in the holding register; load_ready is already 0 if it is full.
    if (xfer && (state_q != IDLE) && !frame_end) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end

    // Frame boundary: a held word takes priority, then a same-cycle offer, else go idle.
    if (frame_end) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        cnt_d       = '0;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
`ifdef SER_PARITY_EN
        parity_d    = ^hold_q;
`endif
      end else if (xfer) begin
        shift_d  = load_data;
        cnt_d    = '0;
        state_d  = SHIFT;
`ifdef SER_PARITY_EN
        parity_d = ^load_data;
`endif
      end else begin
        shift_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
`ifdef SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    ser_bit = 1'b0;
    case (state_q)
      SHIFT:   ser_bit = head_bit;
`ifdef SER_PARITY_EN
      PARITY:  ser_bit = parity_q;
`endif
      default: ser_bit = 1'b0;
    endcase
  end

  assign ser_active = (state_q != IDLE);
  assign frame_done = frame_end;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first serializer share the same stimulus.
module tb_piso_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + (PAR ? 1 : 0);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       rdy_m, bit_m, act_m, done_m;
  logic       rdy_l, bit_l, act_l, done_l;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  logic [1:0] e;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_m), .ser_bit(bit_m), .ser_active(act_m), .frame_done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_l), .ser_bit(bit_l), .ser_active(act_l), .frame_done(done_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      exp_m.push_back({w[7-i], (i == 7) && !PAR});
      exp_l.push_back({w[i],   (i == 7) && !PAR});
    end
    if (PAR) begin
      exp_m.push_back({^w, 1'b1});
      exp_l.push_back({^w, 1'b1});
    end
  endtask

  // Offers a word and leaves load_valid high; the transfer edge is the first one seen with ready.
  task automatic send(input logic [7:0] w, output int waits);
    waits      = 0;
    load_data  = w;
    load_valid = 1'b1;
    while (!rdy_m && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!rdy_m) begin
      check("send ready timeout", rdy_m, 1);
    end else begin
      check("ready agree", rdy_l, rdy_m);
      push_word(w);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_m.size() != 0 || exp_l.size() != 0 || act_m || act_l) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain scoreboard", exp_m.size() + exp_l.size(), 0);
    check("drain idle", act_m | act_l, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (act_m) begin
        if (exp_m.size() == 0) begin
          check("msb active with empty scoreboard", act_m, 0);
        end else begin
          e = exp_m.pop_front();
          check("msb ser_bit", bit_m, e[1]);
          check("msb frame_done", done_m, e[0]);
        end
      end else begin
        check("msb idle ser_bit", bit_m, 0);
        check("msb idle frame_done", done_m, 0);
      end
      if (act_l) begin
        if (exp_l.size() == 0) begin
          check("lsb active with empty scoreboard", act_l, 0);
        end else begin
          e = exp_l.pop_front();
          check("lsb ser_bit", bit_l, e[1]);
          check("lsb frame_done", done_l, e[0]);
        end
      end else begin
        check("lsb idle ser_bit", bit_l, 0);
        check("lsb idle frame_done", done_l, 0);
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset load_ready", rdy_m, 1);
    check("reset ser_active", act_m, 0);
    check("reset ser_bit", bit_m, 0);
    check("reset frame_done", done_m, 0);
    check("reset lsb load_ready", rdy_l, 1);
    rst = 1'b0;

    // Single frame accepted on the first edge after reset release.
    send(8'hE0, w);
    load_valid = 1'b0;
    for (int c = 1; c <= FL + 1; c++) begin
      check("t1 ser_active", act_m, (c <= FL));
      check("t1 frame_done", done_m, (c == FL));
      @(posedge clk); #1;
    end

    // Back-to-back words through the holding register.
    send(8'hA5, w);
    send(8'h3C, w);
    load_valid = 1'b0;
    for (int c = 2; c <= 2 * FL + 1; c++) begin
      check("t2 load_ready", rdy_m, (c > FL));
      check("t2 ser_active", act_m, (c <= 2 * FL));
      @(posedge clk); #1;
    end

    // Offer while hold is full must wait for load_ready and be serialized once.
    send(8'hA5, w);
    send(8'h3C, w);
    send(8'h55, w);
    load_valid = 1'b0;
    check("t3 cycles held off", w, FL - 1);
    wait_idle();

    // Reset in mid-frame with a word parked in hold.
    send(8'hFF, w);
    send(8'h0F, w);
    load_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    exp_m.delete();
    exp_l.delete();
    #1;
    check("t4 async ser_active", act_m, 0);
    check("t4 async ser_bit", bit_m, 0);
    check("t4 async frame_done", done_m, 0);
    check("t4 async load_ready", rdy_m, 1);
    check("t4 async lsb ser_active", act_l, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t4 quiet after reset", act_m | act_l, 0);
      check("t4 ready after reset", rdy_m, 1);
      @(posedge clk); #1;
    end

    // Bit-order and parity words.
    send(8'h01, w);
    send(8'h07, w);
    send(8'h03, w);
    load_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
